// File: rtl/r2r_dac_sequencer_if.sv
// Sample-push handshake between a sample producer and the R2R DAC sequencer.
interface r2r_dac_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/r2r_dac_sequencer.sv
// R2R DAC sequencer: a sample FIFO drained at a programmable rate into CHANNELS
// registered DAC codes, round-robin. Each update pulses that channel's strobe for
// one cycle. A tick that finds the FIFO empty sets the sticky underrun flag.
// Optional build macro R2R_DAC_RAMP_EN adds a test_mode input that replaces FIFO
// samples with an incrementing ramp.
module r2r_dac_sequencer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [15:0]                   div,
    r2r_dac_sequencer_if.slave            s_bus,
    input  logic                          clr_underrun,
`ifdef R2R_DAC_RAMP_EN
    input  logic                          test_mode,
`endif
    output logic [CHANNELS*WIDTH-1:0]     dac_out,
    output logic [CHANNELS-1:0]           dac_strobe,
    output logic [$clog2(DEPTH+1)-1:0]    fill,
    output logic                          underrun
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]             fill_q, fill_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [CW-1:0]             ch_q, ch_d;
    logic [CHANNELS*WIDTH-1:0] dac_q, dac_d;
    logic [CHANNELS-1:0]       strobe_q, strobe_d;
    logic                      underrun_q, underrun_d;

    logic             ready;
    logic             push;
    logic             pop;
    logic             tick;
    logic             fifo_tick;
    logic             ur_set;
    logic             load;
    logic [WIDTH-1:0] load_val;

    // Ready depends only on registered occupancy, never on same-cycle pops.
    assign ready         = (fill_q < FW'(DEPTH));
    assign s_bus.s_ready = ready;
    assign push          = s_bus.s_valid & ready;
    assign tick          = enable & (cnt_q >= div);

`ifdef R2R_DAC_RAMP_EN
    logic             ramp_tick;
    logic [WIDTH-1:0] ramp_q;

    assign ramp_tick = tick & test_mode;
    assign fifo_tick = tick & ~test_mode;

    // Ramp code advances after each test-mode load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp_q <= '0;
        end else if (ramp_tick) begin
            ramp_q <= ramp_q + WIDTH'(1);
        end
    end
`else
    assign fifo_tick = tick;
`endif

    // Decide what (if anything) is loaded into the current channel this tick.
    always_comb begin
        pop      = fifo_tick & (fill_q != '0);
        ur_set   = fifo_tick & (fill_q == '0);
        load     = pop;
        load_val = mem[rd_ptr_q];
`ifdef R2R_DAC_RAMP_EN
        if (ramp_tick) begin
            load     = 1'b1;
            load_val = ramp_q;
        end
`endif
    end

    // Next-state for divider, channel index, outputs, FIFO bookkeeping.
    always_comb begin
        cnt_d    = (enable && !tick) ? cnt_q + 16'd1 : 16'd0;
        ch_d     = ch_q;
        dac_d    = dac_q;
        strobe_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (load && (ch_q == CW'(c))) begin
                dac_d[c*WIDTH +: WIDTH] = load_val;
                strobe_d[c]             = 1'b1;
            end
        end
        if (!enable) begin
            ch_d = '0;
        end else if (load) begin
            ch_d = (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + CW'(1);
        end
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        fill_d     = fill_q + FW'(push) - FW'(pop);
        // A same-edge underrun overrides the clear request.
        underrun_d = ur_set | (underrun_q & ~clr_underrun);
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            cnt_q      <= '0;
            ch_q       <= '0;
            dac_q      <= '0;
            strobe_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            dac_q      <= dac_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    // Sample storage; contents are meaningless outside the occupied window.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_bus.s_data;
        end
    end

    assign dac_out    = dac_q;
    assign dac_strobe = strobe_q;
    assign fill       = fill_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// Bench for r2r_dac_sequencer (WIDTH=8, DEPTH=4, CHANNELS=2) against a queue-based
// reference model of the sequencing rules. Ramp checks are built with R2R_DAC_RAMP_EN.
module tb_r2r_dac_sequencer;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CHANNELS = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      enable = 1'b0;
    logic [15:0]               div = 16'd0;
    logic                      clr_underrun = 1'b0;
    logic                      test_mode = 1'b0;
    logic [CHANNELS*WIDTH-1:0] dac_out;
    logic [CHANNELS-1:0]       dac_strobe;
    logic [2:0]                fill;
    logic                      underrun;

    r2r_dac_sequencer_if #(.WIDTH(WIDTH)) bus ();

    r2r_dac_sequencer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .div          (div),
        .s_bus        (bus),
        .clr_underrun (clr_underrun),
`ifdef R2R_DAC_RAMP_EN
        .test_mode    (test_mode),
`endif
        .dac_out      (dac_out),
        .dac_strobe   (dac_strobe),
        .fill         (fill),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0]    m_q[$];
    logic [WIDTH-1:0]    m_dac[CHANNELS];
    logic [CHANNELS-1:0] m_strobe;
    int                  m_ch;
    int                  m_cnt;
    bit                  m_ur;
    int                  m_ramp;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int c = 0; c < CHANNELS; c++) m_dac[c] = '0;
        m_strobe = '0;
        m_ch     = 0;
        m_cnt    = 0;
        m_ur     = 1'b0;
        m_ramp   = 0;
    endtask

    // One rising edge worth of behaviour, from the inputs currently driven.
    task automatic model_step();
        bit tick;
        bit set_ur;
        bit rdy;
        rdy      = (m_q.size() < DEPTH);
        tick     = enable && (m_cnt >= int'(div));
        m_cnt    = (enable && !tick) ? m_cnt + 1 : 0;
        m_strobe = '0;
        set_ur   = 1'b0;
        if (tick) begin
            if (test_mode) begin
                m_dac[m_ch] = WIDTH'(m_ramp);
                m_strobe    = CHANNELS'(1 << m_ch);
                m_ch        = (m_ch + 1) % CHANNELS;
                m_ramp      = (m_ramp + 1) % (1 << WIDTH);
            end else if (m_q.size() > 0) begin
                m_dac[m_ch] = m_q.pop_front();
                m_strobe    = CHANNELS'(1 << m_ch);
                m_ch        = (m_ch + 1) % CHANNELS;
            end else begin
                set_ur = 1'b1;
            end
        end
        if (!enable) m_ch = 0;
        if (set_ur) m_ur = 1'b1;
        else if (clr_underrun) m_ur = 1'b0;
        if (bus.s_valid && rdy) m_q.push_back(bus.s_data);
    endtask

    task automatic check_all(input string tag);
        logic [CHANNELS*WIDTH-1:0] exp_dac;
        for (int c = 0; c < CHANNELS; c++) exp_dac[c*WIDTH +: WIDTH] = m_dac[c];
        chk({tag, ".dac_out"}, 32'(dac_out), 32'(exp_dac));
        chk({tag, ".strobe"}, 32'(dac_strobe), 32'(m_strobe));
        chk({tag, ".fill"}, 32'(fill), 32'(m_q.size()));
        chk({tag, ".underrun"}, 32'(underrun), 32'(m_ur));
        chk({tag, ".s_ready"}, 32'(bus.s_ready), 32'(m_q.size() < DEPTH));
    endtask

    task automatic edge_step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Pulse reset between edges, then confirm the post-reset state.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("reset");
    endtask

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        model_reset();

        // Reset state
        do_reset();
        chk("reset.dac_zero", 32'(dac_out), 32'h0000);
        chk("reset.ready", 32'(bus.s_ready), 32'd1);

        // Sequencing: three samples, div=3
        for (int i = 1; i <= 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = WIDTH'(i * 16);
            edge_step("seq.push");
        end
        bus.s_valid = 1'b0;
        div         = 16'd3;
        enable      = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            edge_step("seq.run");
            if (e == 3) chk("seq.e3_strobe", 32'(dac_strobe), 32'h0);
            if (e == 4) begin
                chk("seq.e4_dac", 32'(dac_out), 32'h0010);
                chk("seq.e4_strobe", 32'(dac_strobe), 32'h1);
            end
            if (e == 8) begin
                chk("seq.e8_dac", 32'(dac_out), 32'h2010);
                chk("seq.e8_strobe", 32'(dac_strobe), 32'h2);
            end
            if (e == 12) begin
                chk("seq.e12_dac", 32'(dac_out), 32'h2030);
                chk("seq.e12_strobe", 32'(dac_strobe), 32'h1);
            end
        end

        // Full FIFO: fifth push is dropped
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = WIDTH'(8'hA1 + i);
            edge_step("full.push");
        end
        bus.s_valid = 1'b0;
        chk("full.fill", 32'(fill), 32'd4);
        chk("full.ready", 32'(bus.s_ready), 32'd0);
        div    = 16'd0;
        enable = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            edge_step("full.pop");
            if (e == 2) chk("full.pop2", 32'(dac_out), 32'hA2A1);
            if (e == 4) chk("full.pop4", 32'(dac_out), 32'hA4A3);
        end
        chk("full.empty", 32'(fill), 32'd0);

        // Underrun: sticky, set beats clear, ch not advanced
        enable = 1'b0;
        do_reset();
        div    = 16'd0;
        enable = 1'b1;
        edge_step("ur.first");
        chk("ur.set", 32'(underrun), 32'd1);
        chk("ur.dac_held", 32'(dac_out), 32'h0000);
        chk("ur.no_strobe", 32'(dac_strobe), 32'h0);
        clr_underrun = 1'b1;
        edge_step("ur.clr_tick");
        chk("ur.set_wins", 32'(underrun), 32'd1);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        edge_step("ur.push");
        bus.s_valid  = 1'b0;
        clr_underrun = 1'b0;
        edge_step("ur.pop");
        chk("ur.ch0_strobe", 32'(dac_strobe), 32'h1);
        chk("ur.ch0_dac", 32'(dac_out), 32'h005A);
        enable       = 1'b0;
        clr_underrun = 1'b1;
        edge_step("ur.clear");
        chk("ur.cleared", 32'(underrun), 32'd0);
        clr_underrun = 1'b0;

        // Asynchronous reset mid-run with fill=3
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = WIDTH'(8'hB1 + i);
            edge_step("arst.push");
        end
        bus.s_valid = 1'b0;
        enable      = 1'b1;
        edge_step("arst.pop");
        enable = 1'b0;
        chk("arst.pre_fill", 32'(fill), 32'd3);
        rst = 1'b1;
        #1;
        chk("arst.dac", 32'(dac_out), 32'h0000);
        chk("arst.fill", 32'(fill), 32'd0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("arst.release");
        div    = 16'd2;
        enable = 1'b1;
        for (int e = 0; e < 4; e++) edge_step("arst.after");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.s_valid  = ($urandom_range(0, 2) != 0);
            bus.s_data   = WIDTH'($urandom);
            enable       = ($urandom_range(0, 9) != 0);
            clr_underrun = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) div = 16'($urandom_range(0, 4));
            edge_step("rand");
        end
        bus.s_valid  = 1'b0;
        clr_underrun = 1'b0;
        enable       = 1'b0;

`ifdef R2R_DAC_RAMP_EN
        // Ramp test mode: FIFO untouched, no underrun, wraps after max code
        do_reset();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h77;
        edge_step("ramp.push");
        bus.s_valid = 1'b0;
        test_mode   = 1'b1;
        div         = 16'd0;
        enable      = 1'b1;
        for (int e = 1; e <= 260; e++) begin
            edge_step("ramp.run");
            if (e == 1) chk("ramp.e1_strobe", 32'(dac_strobe), 32'h1);
            if (e == 2) chk("ramp.e2_dac", 32'(dac_out), 32'h0100);
            if (e == 257) chk("ramp.wrap", 32'(dac_out[7:0]), 32'h00);
        end
        chk("ramp.fill", 32'(fill), 32'd1);
        chk("ramp.no_ur", 32'(underrun), 32'd0);
        test_mode = 1'b0;
        enable    = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/r2r_dac_sequencer.md
R2R_DAC_SEQUENCER -- requirements
Module: r2r_dac_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per DAC sample.
REQ-002 SHALL have parameter DEPTH, default 16, sample FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter CHANNELS, default 2, number of R2R DAC outputs driven round-robin.
REQ-004 SHALL have clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have enable  in  1  run sequencer; low = idle.
REQ-007 SHALL have div  in  16  sample period minus one, in clk cycles.
REQ-008 SHALL have s_data  in  WIDTH  sample to enqueue.
REQ-009 SHALL have s_valid  in  1  s_data valid.
REQ-010 SHALL have s_ready  out  1  FIFO can accept a sample.
REQ-011 SHALL have clr_underrun  in  1  clear sticky underrun flag.
REQ-012 SHALL have dac_out  out  CHANNELS*WIDTH  registered DAC codes; channel c at bits [c*WIDTH +: WIDTH].
REQ-013 SHALL have dac_strobe  out  CHANNELS  one-cycle pulse on the channel just updated.
REQ-014 SHALL have fill  out  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-015 SHALL have underrun  out  1  sticky; sample tick found FIFO empty.

Function
REQ-016 SHALL accept a push when s_valid and s_ready are both 1 at a rising edge; s_ready SHALL be 1 exactly when fill < DEPTH, driven from registered state only.
REQ-017 SHALL make a pushed sample poppable from the edge after the push; push and pop on the same edge SHALL leave fill unchanged; pointers SHALL wrap DEPTH-1 -> 0.
REQ-018 SHALL, while enable=0, hold divider count and channel index at 0, issue no ticks, hold dac_out, and retain FIFO contents.
REQ-019 SHALL, while enable=1, increment the divider count each edge and raise a tick when count >= div, the count then returning to 0; first tick on the (div+1)th edge with enable sampled 1; div=0 ticks every cycle; div reduced below the current count SHALL tick on the next edge.
REQ-020 SHALL, on a tick with fill > 0, pop the head sample into channel ch of dac_out on that edge, pulse dac_strobe[ch] for the following cycle, and advance ch modulo CHANNELS.
REQ-021 SHALL, on a tick with fill = 0, set underrun, leave dac_out unchanged, assert no strobe, and not advance ch.
REQ-022 SHALL, when clr_underrun and an underrun tick occur on the same edge, leave underrun set (set wins).
REQ-023 SHALL, when the FIFO is full and a tick pops, not accept a same-edge push (s_ready was 0).

Reset
REQ-024 SHALL, on rst=1, immediately clear dac_out, dac_strobe, fill, underrun, FIFO pointers, divider count and ch to 0, and drive s_ready=1 once rst is released (s_ready=0 during reset is permitted).
REQ-025 SHALL discard all queued samples on reset asserted mid-operation; first tick after release follows REQ-019 from count 0.

Configuration
REQ-026 SHALL, with R2R_DAC_RAMP_EN defined, add input test_mode (1 bit); while test_mode=1 each tick SHALL load a WIDTH-bit ramp counter value into channel ch, strobe it, advance ch, then increment the ramp (wrap 2^WIDTH-1 -> 0), with no FIFO pop and no underrun; ramp counter SHALL reset to 0.
REQ-027 SHALL, without R2R_DAC_RAMP_EN, omit test_mode and the ramp counter entirely; behaviour is FIFO-only.

Verification (WIDTH=8, DEPTH=4, CHANNELS=2)
REQ-028 SHALL check reset: rst pulse -> dac_out=0x0000, dac_strobe=00, fill=0, underrun=0, s_ready=1 after release.
REQ-029 SHALL check sequencing: push 0x10,0x20,0x30, div=3, enable=1 -> updates on edges 4, 8, 12: ch0=0x10 (strobe 01), ch1=0x20 (strobe 10), ch0=0x30 (strobe 01); dac_out=0x2030 after edge 12.
REQ-030 SHALL check full: enable=0, push 0xA1..0xA5 back-to-back -> fill=4, s_ready=0, 0xA5 dropped; subsequent pops yield 0xA1..0xA4 in order.
REQ-031 SHALL check underrun: empty FIFO, div=0, enable=1 -> underrun=1 after first edge, dac_out held, no strobe, ch stays 0; clr_underrun=1 concurrent with ticks -> underrun remains 1; clr_underrun with enable=0 -> underrun=0.
REQ-032 SHALL check async reset mid-run: rst asserted between edges with fill=3 -> dac_out and fill read 0 before the next edge.
REQ-033 SHALL check ramp (R2R_DAC_RAMP_EN): test_mode=1, div=0 -> ch0=0x00, ch1=0x01, ch0=0x02, ...; after 0xFF the next code is 0x00; fill unchanged, underrun=0.
